brent_kung_add_pipe: RTL and testbench
======================================

# brent_kung_add_pipe

Parametrised, pipelined Brent-Kung prefix adder/subtractor with a valid/ready stream interface. It supports carry-in, subtraction, and multi-word carry chaining across consecutive beats. It replaces the fixed 12-bit combinational Brent-Kung adder in datapaths that need registered timing, wider operands or multi-precision arithmetic. It sits between an operand-producing stage and any downstream consumer that can apply backpressure.

## Interface
- WIDTH, 12, operand/sum width in bits; legal range 2..64.
- PIPE, 2, register stages from input acceptance to output; legal range 1..clog2(WIDTH)+1.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add) / borrow-in (sub); ignored when in_chain=1.
- in_sub  in  1  1: compute A - B; 0: compute A + B.
- in_chain  in  1  1: carry-in is the cout of the previous beat to leave the pipeline.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry-out; for subtraction this is not-borrow.
- out_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Effective B: b_eff = in_sub ? ~in_b : in_b.
- Effective carry-in: cin_eff = in_chain ? carry_q : (in_sub ? ~in_cin : in_cin).
- Result: {out_cout, out_sum} = in_a + b_eff + cin_eff, computed modulo 2^(WIDTH+1).
- Generate/propagate, the Brent-Kung up-sweep and the down-sweep prefix levels are distributed across PIPE stages. The final stage combines the group (G,P) prefixes with cin_eff, so carry_q is needed only at the last stage.
- The chain mode bit is carried down the pipeline with the beat. in_cin and in_sub are also carried with the beat.
- carry_q is updated with out_cout whenever a beat is loaded into the output register. Beats load in order, so a chained beat always sees the cout of its immediate predecessor, including back-to-back beats.
- Chained subtraction (sub=1, chain=1) uses carry_q directly as not-borrow, which gives correct multi-word subtraction.
- Global stall control:
  - advance = !out_valid | out_ready.
  - in_ready = advance & !rst.
  - All stage registers and their valid bits shift only when advance=1.
  - Bubbles are not compressed.
- There is no state machine beyond the per-stage valid bits and carry_q.

## Timing
- Reset values: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, carry_q=0, all stage valid bits 0.
- While rst=1, in_ready=0.
- Latency: a beat accepted at edge N (in_valid & in_ready) appears with out_valid=1 after edge N+PIPE-1, i.e. it is visible at the output PIPE cycles after the cycle in which it is presented, provided no stall occurs.
- Throughput is 1 beat per cycle when out_ready is held at 1.
- Backpressure:
  - out_valid=1 & out_ready=0 drops in_ready combinationally in the same cycle.
  - Output data holds stable until accepted.
  - No beat is lost, duplicated or reordered.
- Simultaneous accept at input and output in one cycle is legal and maintains full rate.
- Reset mid-operation discards all in-flight beats; the first post-reset chained beat uses carry 0.
- Chaining starts fresh at out_ready stalls: carry_q updates only on output-register load, never on stall cycles.
- Wrap-around: sums are modulo 2^WIDTH, and the overflow condition is reported only through out_cout and out_ovf.

## Test plan
- Carry ripple (WIDTH=12, PIPE=2): A=0xFFF, B=0x001, cin=0 -> sum 0x000, cout=1, ovf=0, out_valid 2 cycles after presentation.
- Subtract and overflow:
  - A=0x005, B=0x007, sub=1, cin=0 -> sum 0xFFE, cout=0, ovf=0.
  - A=0x7FF, B=0x001, add -> sum 0x800, ovf=1, cout=0.
- Back-to-back chain:
  - Beat 1: A=0xFFF, B=0x001, chain=0 -> 0x000, cout=1.
  - Beat 2 (next cycle): A=0x000, B=0x000, chain=1 -> 0x001, cout=0.
  - Beat 3: sub=1, chain=1, A=0, B=0 -> carry_q=0 gives 0xFFF, cout=0.
- Backpressure: stream 6 beats while holding out_ready=0 for 5 cycles -> in_ready falls the cycle stall begins, out_sum stable, all 6 results emitted once in order.
- Reset mid-stream: 2 beats in flight, assert rst 1 cycle -> out_valid=0 the next cycle, neither beat ever emitted; next chained beat A=1, B=1 -> sum 0x002.
- Random regression: 10k random beats, random in_valid/out_ready, WIDTH in {12, 32, 64}, PIPE in {1, max}, checked against a behavioural scoreboard (a + b_eff + cin_eff with carry_q model).

Source files
------------

// File: rtl/brent_kung_add_pipe.sv
// Pipelined Brent-Kung prefix adder/subtractor with a valid/ready stream interface.
//
// Computes {out_cout, out_sum} = in_a + (in_sub ? ~in_b : in_b) + cin_eff, where cin_eff is
// the previous output beat's carry when in_chain=1, else in_cin (inverted for subtraction).
// The up-sweep and down-sweep prefix levels are spread over PIPE register stages; the
// carry-in is folded in only at the last stage so chained beats can run back to back.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid / in_ready       operand handshake
//   in_a, in_b                operands (WIDTH bits)
//   in_cin, in_sub, in_chain  carry/borrow-in, subtract select, multi-word chain select
//   out_valid / out_ready     result handshake
//   out_sum, out_cout, out_ovf  result, carry-out (not-borrow for sub), signed overflow
module brent_kung_add_pipe #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int unsigned Lvls   = $clog2(WIDTH);
    // Level 0 is g/p generation, levels 1..Lvls the up-sweep, the rest the down-sweep.
    localparam int unsigned NumLvl = 2 * Lvls - 1;
    localparam int unsigned NumPos = NumLvl + 1;

    // A stage register follows level `pos` when it is one of the PIPE-1 evenly spaced cuts.
    // Spacing is at least one level because PIPE <= Lvls + 1 <= NumPos.
    function automatic bit is_cut(int unsigned pos);
        bit hit;
        hit = 1'b0;
        for (int unsigned k = 1; k < PIPE; k++) begin
            if ((k * NumPos) / PIPE - 1 == pos) hit = 1'b1;
        end
        return hit;
    endfunction

    // Span combined at each prefix level.
    function automatic int unsigned lvl_dist(int unsigned lvl);
        if (lvl <= Lvls) return 1 << (lvl - 1);
        return 1 << (2 * Lvls - 1 - lvl);
    endfunction

    typedef struct packed {
        logic             valid;
        logic             chain;
        logic             sub;
        logic             cin;
        logic [WIDTH-1:0] hs;   // bitwise half sum a ^ b_eff, kept for the final xor
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } beat_t;

    logic             advance;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;
    logic             out_ovf_q;
    logic             carry_q;

    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance & ~rst;

    for (genvar j = 0; j <= NumLvl; j++) begin : g_lvl
        beat_t cur;
        beat_t nxt;

        if (j == 0) begin : g_gp
            logic [WIDTH-1:0] b_eff;
            assign b_eff = in_sub ? ~in_b : in_b;
            assign cur = '{valid: in_valid, chain: in_chain, sub: in_sub, cin: in_cin,
                           hs: in_a ^ b_eff, g: in_a & b_eff, p: in_a ^ b_eff};
        end else begin : g_pre
            localparam bit          Up   = (j <= Lvls);
            localparam int unsigned Dist = lvl_dist(j);
            beat_t            prv;
            logic [WIDTH-1:0] g_new;
            logic [WIDTH-1:0] p_new;

            assign prv = g_lvl[j-1].nxt;

            // Up-sweep touches every 2*Dist-th bit; down-sweep fills the midpoints that lie
            // above an already complete prefix.
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (Up ? ((i + 1) % (2 * Dist) == 0)
                       : (((i + 1) % (2 * Dist) == Dist) && (i + 1 > 2 * Dist))) begin : g_op
                    assign g_new[i] = prv.g[i] | (prv.p[i] & prv.g[i-Dist]);
                    assign p_new[i] = prv.p[i] & prv.p[i-Dist];
                end else begin : g_pass
                    assign g_new[i] = prv.g[i];
                    assign p_new[i] = prv.p[i];
                end
            end

            always_comb begin
                cur   = prv;
                cur.g = g_new;
                cur.p = p_new;
            end
        end

        if (is_cut(j)) begin : g_reg
            beat_t stage_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_q <= '0;
                end else if (advance) begin
                    stage_q <= cur;
                end
            end
            assign nxt = stage_q;
        end else begin : g_wire
            assign nxt = cur;
        end
    end

    // Final stage: every position now holds the group prefix over [0..i].
    beat_t            fin;
    logic             cin_eff;
    logic [WIDTH:0]   carry;    // carry[i] enters bit i; carry[WIDTH] is the carry-out
    logic [WIDTH-1:0] sum_d;

    assign fin = g_lvl[NumLvl].nxt;

    always_comb begin
        // Chained beats take the stored carry as-is; for subtraction it is already not-borrow.
        cin_eff  = fin.chain ? carry_q : (fin.sub ? ~fin.cin : fin.cin);
        carry[0] = cin_eff;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = fin.g[i] | (fin.p[i] & cin_eff);
        end
    end

    assign sum_d = fin.hs ^ carry[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            carry_q     <= 1'b0;
        end else if (advance) begin
            out_valid_q <= fin.valid;
            // Bubbles leave the result and the chain carry untouched.
            if (fin.valid) begin
                out_sum_q  <= sum_d;
                out_cout_q <= carry[WIDTH];
                out_ovf_q  <= carry[WIDTH-1] ^ carry[WIDTH];
                carry_q    <= carry[WIDTH];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_brent_kung_add_pipe.sv
// Self-checking bench for brent_kung_add_pipe: directed vector table, latency, backpressure,
// mid-stream reset, and a randomized run against an arithmetic scoreboard.
module tb_brent_kung_add_pipe;
    localparam int unsigned W       = 12;
    localparam int unsigned P       = 2;
    localparam int          NumRand = 3000;
    localparam int          NumTbl  = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         in_chain;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    brent_kung_add_pipe #(
        .WIDTH(W),
        .PIPE (P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .in_chain (in_chain),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic         chain;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];
    res_t got_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h at %0t", name, got, req, $time);
        end
    endtask

    // Scoreboard: the model carry is the cout of the last accepted beat, since beats leave
    // in order and a reset throws away everything in flight.
    logic         mdl_carry;
    logic [W-1:0] mdl_be;
    logic         mdl_ce;
    logic [W:0]   mdl_full;
    res_t         mon_got;
    res_t         mon_exp;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mdl_carry = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                mon_got = '{sum: out_sum, cout: out_cout, ovf: out_ovf};
                got_q.push_back(mon_got);
                if (exp_q.size() == 0) begin
                    check("sb_extra_beat", 64'(exp_q.size()), 64'(1));
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("sb_result", 64'(mon_got), 64'(mon_exp));
                end
            end
            if (in_valid && in_ready) begin
                mdl_be   = in_sub ? ~in_b : in_b;
                mdl_ce   = in_chain ? mdl_carry : (in_sub ? ~in_cin : in_cin);
                mdl_full = {1'b0, in_a} + {1'b0, mdl_be} + {{W{1'b0}}, mdl_ce};
                mon_exp.sum  = mdl_full[W-1:0];
                mon_exp.cout = mdl_full[W];
                mon_exp.ovf  = (in_a[W-1] == mdl_be[W-1]) && (mdl_full[W-1] != in_a[W-1]);
                exp_q.push_back(mon_exp);
                mdl_carry = mdl_full[W];
            end
        end
    end

    // Present one beat (called just after a rising edge); returns just after its accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic chain);
        int cnt;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_chain = chain;
        in_valid = 1'b1;
        cnt      = 0;
        @(negedge clk);
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("send_accept", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check(name, 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [NumTbl];
    int   cnt;
    int   seen;
    int   sent;
    int   cyc;
    logic acc;
    logic [W-1:0] held;

    initial begin
        tbl[0]  = '{12'hFFF, 12'h001, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0};
        tbl[1]  = '{12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 12'h001, 1'b0, 1'b0};
        tbl[2]  = '{12'h000, 12'h000, 1'b0, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0};
        tbl[3]  = '{12'h005, 12'h007, 1'b0, 1'b1, 1'b0, 12'hFFE, 1'b0, 1'b0};
        tbl[4]  = '{12'h7FF, 12'h001, 1'b0, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1};
        tbl[5]  = '{12'h800, 12'h800, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1};
        tbl[6]  = '{12'h123, 12'h456, 1'b1, 1'b0, 1'b0, 12'h57A, 1'b0, 1'b0};
        tbl[7]  = '{12'h010, 12'h003, 1'b1, 1'b1, 1'b0, 12'h00C, 1'b1, 1'b0};
        tbl[8]  = '{12'hFFF, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0};
        tbl[9]  = '{12'h000, 12'h000, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0};
        tbl[10] = '{12'h800, 12'h001, 1'b0, 1'b1, 1'b0, 12'h7FF, 1'b1, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        in_chain  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'(0));
        check("reset_outputs", 64'({out_valid, out_sum, out_cout, out_ovf}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, streamed back to back.
        got_q.delete();
        for (int i = 0; i < NumTbl; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].chain);
        end
        cnt = 0;
        while (got_q.size() < NumTbl && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("tbl_count", 64'(got_q.size()), 64'(NumTbl));
        for (int i = 0; i < NumTbl && i < got_q.size(); i++) begin
            check($sformatf("tbl_vec%0d", i), 64'(got_q[i]),
                  64'({tbl[i].sum, tbl[i].cout, tbl[i].ovf}));
        end
        drain("tbl_drain");

        // Latency on an idle pipe.
        send(12'hFFF, 12'h001, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("latency", 64'(cnt), 64'(P - 1));
        drain("latency_drain");

        // Backpressure: output stalled for 5 cycles while 6 beats stream in.
        got_q.delete();
        out_ready = 1'b0;
        fork
            begin : bp_src
                for (int i = 0; i < 6; i++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                end
            end
            begin : bp_stall
                int c;
                c = 0;
                while (!out_valid && c < 50) begin
                    @(negedge clk);
                    c++;
                end
                check("bp_ready_drop", 64'({out_valid, in_ready}), 64'(2'b10));
                held = out_sum;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold", 64'({in_ready, out_sum}), 64'({1'b0, held}));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_count", 64'(got_q.size()), 64'(6));

        // Reset with two beats in flight; the first leaves carry_q=1 behind it.
        send(12'hFFF, 12'h001, 1'b0, 1'b0, 1'b0);
        send(12'h00A, 12'h003, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_flush_valid", 64'(out_valid), 64'(0));
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_emit", 64'(seen), 64'(0));
        @(posedge clk);
        #1;
        got_q.delete();
        send(12'h001, 12'h001, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        while (got_q.size() < 1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_chain_cnt", 64'(got_q.size()), 64'(1));
        if (got_q.size() > 0) begin
            check("rst_chain_sum", 64'(got_q[0]), 64'({12'h002, 1'b0, 1'b0}));
        end
        drain("rst_drain");

        // Randomized traffic with random valid/ready, checked by the scoreboard.
        sent = 0;
        cyc  = 0;
        while (sent < NumRand && cyc < 40000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) sent++;
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a     = W'($urandom);
                in_b     = W'($urandom);
                in_cin   = 1'($urandom);
                in_sub   = 1'($urandom);
                in_chain = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_sent", 64'(sent), 64'(NumRand));
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
